memarray_par: RTL and testbench
===============================

# memarray_par

Parametrised successor to the 128KW byte-lane memory array: NLANES byte lanes of 9 bits (8 data + 1 parity), 2^ADDRW words, configurable read latency. It adds parity generation, parity checking with per-lane error flags, a sticky error register with failing-address capture, and a clear-sweep sequencer that zeroes the array with good parity. It sits between the bus memory controller and the block-RAM inference point. LATENCY=2 with PARGEN=0 reproduces legacy read/write timing.

## Interface
- ADDRW, 17, address width; depth = 2^ADDRW words
- NLANES, 2, byte lanes per word; word width W = 9*NLANES
- LATENCY, 2, read latency in clocks, legal 1..4
- PARGEN, 1, 1 = parity bit generated from data on write (dina parity bits ignored); 0 = dina parity bits stored as supplied
- AUTOINIT, 1, 1 = clear-sweep starts automatically on reset release
- IDLEPAT, 18'o615243 replicated/truncated to W, value driven on douta when no valid read
- clka  in  1  clock, rising edge
- rstna  in  1  reset, asynchronous, active-low
- ena  in  1  access enable
- wea  in  NLANES  per-lane write enable (lane i = dina[9i+8:9i])
- addra  in  ADDRW  word address
- dina  in  W  write data; bit 9i+8 is lane i parity
- parinj  in  NLANES  per-lane fault inject: invert stored parity bit on write
- douta  out  W  read data
- dvalid  out  1  douta holds a valid read result
- perr  out  NLANES  per-lane parity error, aligned with douta
- errsticky  out  1  sticky parity-error flag
- erraddr  out  ADDRW  address of first error since last clear
- errclr  in  1  clear errsticky/erraddr
- initreq  in  1  start clear-sweep
- busy  out  1  clear-sweep in progress

## Operation
- Parity is odd: each stored 9-bit lane has an odd number of ones; zero byte stores parity 1.
- Access accepted when ena=1 and busy=0. Read always performed; write per lane where wea[i]=1. Same-cycle read/write of one address returns OLD data.
- Stored parity for lane i: PARGEN ? ~^data : dina[9i+8], XOR parinj[i].
- Read pipeline: stage 1 registers array output; stages 2..LATENCY delay it. Address and valid bit travel alongside. An unaccepted cycle inserts an invalid bubble carrying IDLEPAT.
- Check at output: perr[i] = dvalid & (^douta lane i == 0).
- errsticky sets on any perr; erraddr loads the pipelined address only when errsticky was 0. errclr clears both next edge; simultaneous errclr and new perr: set and capture win.
- Sweep FSM, states IDLE, SWEEP. IDLE->SWEEP on initreq (or reset release with AUTOINIT). SWEEP writes all lanes data 0 with parity 1 to counter address, counter 0 upward, one word per clock; after address 2^ADDRW-1 -> IDLE. busy=1 in SWEEP. Bus accesses ignored while busy (no write, bubble inserted). initreq while busy ignored.

## Timing
- Reset (rstna=0, immediate): douta=IDLEPAT, all pipeline stages IDLEPAT/invalid, dvalid=0, perr=0, errsticky=0, erraddr=0, sweep counter 0, FSM IDLE. Array contents not reset.
- First clock after release: busy=1 if AUTOINIT, else 0. Sweep takes exactly 2^ADDRW cycles; busy falls on the edge after the last write.
- Read accepted at edge N: douta/dvalid/perr valid after edge N+LATENCY-1 (i.e. in cycle N+LATENCY). Fully pipelined: one read per clock.
- errsticky/erraddr update one edge after perr asserts.
- Reset mid-sweep aborts; restarts from address 0 on release if AUTOINIT.

## Structure
- Package memarray_pkg: odd-parity function, default IDLEPAT constant, FSM state enum.
- Sub-module memarray_lane: one 9-bit x 2^ADDRW lane array with write enable, registered read; instantiated NLANES times.

## Test plan
- ADDRW=4, AUTOINIT=1: release reset -> busy high exactly 16 cycles; read all addresses -> douta=18'o400400 (parity 1 each lane), perr=0.
- LATENCY=2: write 16'o123456 to addr 3, read at edge N -> douta data 8'o247/8'o056 with generated parity, dvalid in cycle N+2; sweep LATENCY 1..4 likewise.
- parinj=2'b01 write addr 5, read -> perr=2'b01, errsticky=1 next edge, erraddr=5; second error at addr 7 -> erraddr stays 5; errclr with coincident error at 9 -> errsticky=1, erraddr=9.
- Same-cycle write 0x55 and read addr 2 (old 0) -> returns 0; following read -> 0x55.
- ena=0 cycles and accesses during busy -> douta=IDLEPAT, dvalid=0, no array change.
- Assert rstna mid-sweep at address 8 -> outputs reset at once; on release sweep restarts at 0, busy 16 cycles.

Source files
------------

// File: rtl/memarray_pkg.sv
// Shared definitions for the parity-protected byte-lane memory array:
// odd-parity helper, default idle pattern and clear-sweep state encoding.
package memarray_pkg;

  localparam logic [17:0] IDLEPAT_DEFAULT = 18'o615243;
  localparam int          LANE_W          = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  // Parity bit that makes {parity, data} contain an odd number of ones.
  function automatic logic oddParity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/memarray_lane.sv
// One 9-bit byte lane (8 data + parity) of the array, with a registered,
// read-before-write output port.
module memarray_lane #(
  parameter int ADDRW = 17
) (
  input  logic             clka,
  input  logic             i_we,
  input  logic [ADDRW-1:0] i_addr,
  input  logic [8:0]       i_din,
  output logic [8:0]       o_dout
);

  logic [8:0] r_mem [2**ADDRW];
  logic [8:0] r_dout;

  // No reset on the storage or read register so this maps onto block RAM.
  always_ff @(posedge clka) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/memarray_par.sv
// Parametrised byte-lane memory array with odd-parity generation/checking,
// sticky error capture, configurable read latency and a clear-sweep sequencer.
module memarray_par
  import memarray_pkg::*;
#(
  parameter int          ADDRW    = 17,
  parameter int          NLANES   = 2,
  parameter int          LATENCY  = 2,
  parameter int          PARGEN   = 1,
  parameter int          AUTOINIT = 1,
  parameter logic [17:0] IDLEPAT  = IDLEPAT_DEFAULT,
  localparam int         W        = LANE_W * NLANES
) (
  input  logic              clka,
  input  logic              rstna,
  input  logic              ena,
  input  logic [NLANES-1:0] wea,
  input  logic [ADDRW-1:0]  addra,
  input  logic [W-1:0]      dina,
  input  logic [NLANES-1:0] parinj,
  output logic [W-1:0]      douta,
  output logic              dvalid,
  output logic [NLANES-1:0] perr,
  output logic              errsticky,
  output logic [ADDRW-1:0]  erraddr,
  input  logic              errclr,
  input  logic              initreq,
  output logic              busy
);

  localparam int                 REPS     = (W + 17) / 18;
  localparam logic [18*REPS-1:0] IDLE_REP = {REPS{IDLEPAT}};
  localparam logic [W-1:0]       IDLE_W   = IDLE_REP[W-1:0];

  sweep_state_e     r_state;
  sweep_state_e     w_stateNext;
  logic [ADDRW-1:0] r_sweepCnt;
  logic             r_autoPend;
  logic             w_sweeping;
  logic             w_sweepLast;
  logic             w_accept;
  logic [ADDRW-1:0] w_addr;
  logic [W-1:0]     w_laneOut;

  logic [LATENCY-1:0] r_valid;
  logic [ADDRW-1:0]   r_addr  [LATENCY];
  logic [W-1:0]       w_stage [LATENCY];
  logic [ADDRW-1:0]   w_outAddr;
  logic               w_anyErr;
  logic               r_errSticky;
  logic [ADDRW-1:0]   r_errAddr;

  assign w_sweeping  = (r_state == ST_SWEEP);
  assign w_sweepLast = (r_sweepCnt == {ADDRW{1'b1}});
  assign w_accept    = ena & ~w_sweeping;
  assign w_addr      = w_sweeping ? r_sweepCnt : addra;
  assign busy        = w_sweeping;

  // r_autoPend launches the sweep on the first edge after reset release.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      r_state    <= ST_IDLE;
      r_sweepCnt <= '0;
      r_autoPend <= (AUTOINIT != 0);
    end else begin
      r_state    <= w_stateNext;
      r_autoPend <= 1'b0;
      if (w_sweeping) begin
        r_sweepCnt <= r_sweepCnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (initreq || r_autoPend) w_stateNext = ST_SWEEP;
      ST_SWEEP: if (w_sweepLast)           w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    logic [7:0] w_data;
    logic       w_parSrc;
    logic [8:0] w_din;
    logic       w_we;

    assign w_data   = dina[9*i +: 8];
    assign w_parSrc = (PARGEN != 0) ? oddParity(w_data) : dina[9*i+8];
    assign w_din    = w_sweeping ? 9'h100 : {w_parSrc ^ parinj[i], w_data};
    assign w_we     = w_sweeping | (w_accept & wea[i]);

    memarray_lane #(.ADDRW(ADDRW)) u_lane (
      .clka   (clka),
      .i_we   (w_we),
      .i_addr (w_addr),
      .i_din  (w_din),
      .o_dout (w_laneOut[9*i +: 9])
    );

    assign perr[i] = dvalid & ~(^douta[9*i +: 9]);
  end

  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      r_valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_addr[k] <= '0;
      end
    end else begin
      r_valid[0] <= w_accept;
      r_addr[0]  <= addra;
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  end

  // The lane read register is unreset; an invalid stage 1 shows the idle pattern instead.
  assign w_stage[0] = r_valid[0] ? w_laneOut : IDLE_W;

  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    logic [W-1:0] r_data;

    always_ff @(posedge clka or negedge rstna) begin
      if (!rstna) begin
        r_data <= IDLE_W;
      end else begin
        r_data <= w_stage[k-1];
      end
    end

    assign w_stage[k] = r_data;
  end

  assign douta     = w_stage[LATENCY-1];
  assign dvalid    = r_valid[LATENCY-1];
  assign w_outAddr = r_addr[LATENCY-1];
  assign w_anyErr  = |perr;

  // A new error beats a coincident clear, and also re-arms the address capture.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      r_errSticky <= 1'b0;
      r_errAddr   <= '0;
    end else if (w_anyErr) begin
      r_errSticky <= 1'b1;
      if (!r_errSticky || errclr) begin
        r_errAddr <= w_outAddr;
      end
    end else if (errclr) begin
      r_errSticky <= 1'b0;
      r_errAddr   <= '0;
    end
  end

  assign errsticky = r_errSticky;
  assign erraddr   = r_errAddr;

endmodule

// File: tb/tb_memarray_par.sv
// Scoreboard bench for memarray_par: four instances (LATENCY 1..4) share one
// directed stimulus stream; a monitor per instance pops expected reads.
module tb_memarray_par;

  localparam int          ADDRW   = 4;
  localparam int          NINST   = 4;
  localparam int          MAIN    = 1;
  localparam logic [17:0] IDLE    = 18'o615243;
  localparam logic [17:0] CLEARED = 18'o400400;
  localparam logic [17:0] JUNK    = 18'o777777;

  typedef struct {
    logic [17:0] data;
    logic [1:0]  perr;
    int          edgeNo;
  } exp_t;

  logic             clka    = 1'b0;
  logic             rstna   = 1'b1;
  logic             ena     = 1'b0;
  logic             errclr  = 1'b0;
  logic             initreq = 1'b0;
  logic [1:0]       wea     = '0;
  logic [1:0]       parinj  = '0;
  logic [ADDRW-1:0] addra   = '0;
  logic [17:0]      dina    = '0;

  logic [17:0]      doutaArr     [NINST];
  logic             dvalidArr    [NINST];
  logic [1:0]       perrArr      [NINST];
  logic             errstickyArr [NINST];
  logic [ADDRW-1:0] erraddrArr   [NINST];
  logic             busyArr      [NINST];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          nBusy;
  exp_t        expList[$];
  logic [17:0] model [16];

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0o expected %0o", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] lanePerr(input logic [17:0] w);
    return {~(^w[17:9]), ~(^w[8:0])};
  endfunction

  for (genvar k = 0; k < NINST; k++) begin : g_dut
    int idx = 0;

    memarray_par #(
      .ADDRW(ADDRW), .NLANES(2), .LATENCY(k + 1),
      .PARGEN(1), .AUTOINIT(1), .IDLEPAT(IDLE)
    ) u_dut (
      .clka      (clka),
      .rstna     (rstna),
      .ena       (ena),
      .wea       (wea),
      .addra     (addra),
      .dina      (dina),
      .parinj    (parinj),
      .douta     (doutaArr[k]),
      .dvalid    (dvalidArr[k]),
      .perr      (perrArr[k]),
      .errsticky (errstickyArr[k]),
      .erraddr   (erraddrArr[k]),
      .errclr    (errclr),
      .initreq   (initreq),
      .busy      (busyArr[k])
    );

    // Monitor: every valid output pops the next expected read for this instance.
    always @(negedge clka) begin
      if (dvalidArr[k]) begin
        if (idx >= expList.size()) begin
          checks++;
          failures++;
          $display("[TB] FAIL L%0d unexpected valid: got douta %0o expected no read", k + 1, doutaArr[k]);
        end else begin
          checkOutput($sformatf("L%0d douta", k + 1), doutaArr[k], expList[idx].data);
          checkOutput($sformatf("L%0d perr", k + 1), perrArr[k], expList[idx].perr);
          checkOutput($sformatf("L%0d latency edge", k + 1), cyc, expList[idx].edgeNo + k);
          idx++;
        end
      end else begin
        checkOutput($sformatf("L%0d idle douta", k + 1), doutaArr[k], IDLE);
        checkOutput($sformatf("L%0d idle perr", k + 1), perrArr[k], 2'b00);
      end
    end
  end

  // Drive one cycle of bus inputs; an accepted access always produces a read of the old word.
  task automatic applyStimulus(input logic en, input logic [1:0] we, input logic [ADDRW-1:0] addr,
                               input logic [17:0] din, input logic [1:0] pinj, input logic [17:0] stored);
    exp_t e;
    @(negedge clka);
    ena = en; wea = we; addra = addr; dina = din; parinj = pinj;
    if (en) begin
      e.data   = model[addr];
      e.perr   = lanePerr(model[addr]);
      e.edgeNo = cyc + 1;
      expList.push_back(e);
      for (int i = 0; i < 2; i++) begin
        if (we[i]) model[addr][9*i +: 9] = stored[9*i +: 9];
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, '0, '0, 2'b00, '0);
  endtask

  task automatic readAll();
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 2'b00, a[ADDRW-1:0], '0, 2'b00, '0);
  endtask

  task automatic clearModel();
    for (int a = 0; a < 16; a++) model[a] = CLEARED;
  endtask

  // Count busy cycles while hammering the bus with writes that must be ignored.
  task automatic countBusy(input int stopAt, output int n);
    n = 0;
    @(negedge clka);
    checkOutput("busy at sweep start", busyArr[MAIN], 1'b1);
    ena = 1'b1; wea = 2'b11; addra = 4'd4; dina = JUNK;
    for (int t = 0; t < 64; t++) begin
      if (!busyArr[MAIN]) break;
      n++;
      if (n == stopAt) return;
      initreq = (n == 5);
      @(negedge clka);
    end
    ena = 1'b0; wea = 2'b00; initreq = 1'b0;
  endtask

  initial begin
    #1 rstna = 1'b0;
    repeat (3) @(negedge clka);
    checkOutput("reset douta", doutaArr[MAIN], IDLE);
    checkOutput("reset dvalid", dvalidArr[MAIN], 1'b0);
    checkOutput("reset errsticky", errstickyArr[MAIN], 1'b0);
    checkOutput("reset erraddr", erraddrArr[MAIN], 4'd0);
    checkOutput("reset busy", busyArr[MAIN], 1'b0);

    rstna = 1'b1;
    countBusy(0, nBusy);
    checkOutput("auto sweep length", nBusy, 16);
    clearModel();
    readAll();

    applyStimulus(1'b1, 2'b11, 4'd3, {1'b1, 8'hA7, 1'b0, 8'h2E}, 2'b00, {1'b0, 8'hA7, 1'b1, 8'h2E});
    applyStimulus(1'b1, 2'b00, 4'd3, '0, 2'b00, '0);

    applyStimulus(1'b1, 2'b01, 4'd2, {9'h000, 1'b0, 8'h55}, 2'b00, {9'h000, 1'b1, 8'h55});
    applyStimulus(1'b1, 2'b00, 4'd2, '0, 2'b00, '0);

    applyStimulus(1'b0, 2'b11, 4'd3, JUNK, 2'b00, JUNK);
    applyStimulus(1'b0, 2'b11, 4'd3, JUNK, 2'b00, JUNK);
    applyStimulus(1'b1, 2'b00, 4'd3, '0, 2'b00, '0);
    repeat (5) idle();

    applyStimulus(1'b1, 2'b11, 4'd5, {1'b0, 8'h12, 1'b0, 8'h34}, 2'b01, {1'b1, 8'h12, 1'b1, 8'h34});
    applyStimulus(1'b1, 2'b00, 4'd5, '0, 2'b00, '0);
    idle();
    idle();
    checkOutput("errsticky before update", errstickyArr[MAIN], 1'b0);
    idle();
    checkOutput("errsticky first error", errstickyArr[MAIN], 1'b1);
    checkOutput("erraddr first error", erraddrArr[MAIN], 4'd5);

    applyStimulus(1'b1, 2'b11, 4'd7, {1'b0, 8'h00, 1'b0, 8'hFF}, 2'b10, {1'b0, 8'h00, 1'b1, 8'hFF});
    applyStimulus(1'b1, 2'b00, 4'd7, '0, 2'b00, '0);
    repeat (4) idle();
    checkOutput("errsticky second error", errstickyArr[MAIN], 1'b1);
    checkOutput("erraddr held", erraddrArr[MAIN], 4'd5);

    applyStimulus(1'b1, 2'b11, 4'd9, {1'b0, 8'h01, 1'b0, 8'h01}, 2'b11, {1'b1, 8'h01, 1'b1, 8'h01});
    applyStimulus(1'b1, 2'b00, 4'd9, '0, 2'b00, '0);
    idle();
    idle();
    errclr = 1'b1;
    idle();
    errclr = 1'b0;
    checkOutput("errsticky clear vs error", errstickyArr[MAIN], 1'b1);
    checkOutput("erraddr clear vs error", erraddrArr[MAIN], 4'd9);
    errclr = 1'b1;
    idle();
    errclr = 1'b0;
    checkOutput("errsticky cleared", errstickyArr[MAIN], 1'b0);
    checkOutput("erraddr cleared", erraddrArr[MAIN], 4'd0);
    repeat (5) idle();

    @(negedge clka);
    initreq = 1'b1;
    countBusy(0, nBusy);
    checkOutput("initreq sweep length", nBusy, 16);
    clearModel();
    readAll();
    repeat (5) idle();

    applyStimulus(1'b1, 2'b11, 4'd5, {1'b0, 8'h12, 1'b0, 8'h34}, 2'b01, {1'b1, 8'h12, 1'b1, 8'h34});
    applyStimulus(1'b1, 2'b00, 4'd5, '0, 2'b00, '0);
    repeat (6) idle();
    checkOutput("errsticky before mid-sweep reset", errstickyArr[MAIN], 1'b1);
    @(negedge clka);
    initreq = 1'b1;
    countBusy(9, nBusy);
    #2 rstna = 1'b0;
    ena = 1'b0; wea = 2'b00; initreq = 1'b0;
    #1;
    checkOutput("mid-sweep reset busy", busyArr[MAIN], 1'b0);
    checkOutput("mid-sweep reset dvalid", dvalidArr[MAIN], 1'b0);
    checkOutput("mid-sweep reset douta", doutaArr[MAIN], IDLE);
    checkOutput("mid-sweep reset errsticky", errstickyArr[MAIN], 1'b0);
    repeat (2) @(negedge clka);
    rstna = 1'b1;
    countBusy(0, nBusy);
    checkOutput("restarted sweep length", nBusy, 16);
    clearModel();
    readAll();
    repeat (6) idle();

    checkOutput("L1 reads consumed", g_dut[0].idx, expList.size());
    checkOutput("L2 reads consumed", g_dut[1].idx, expList.size());
    checkOutput("L3 reads consumed", g_dut[2].idx, expList.size());
    checkOutput("L4 reads consumed", g_dut[3].idx, expList.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
